bidir_channel_ctrl: RTL and testbench
=====================================

# bidir_channel_ctrl

Parametrised per-endpoint controller for one bidirectional inter-router channel. It arbitrates NREQ local requesters onto the channel with a registered round-robin arbiter that holds each grant for a whole packet. It also negotiates channel direction with the controller at the far end using a token handshake, with a turnaround bubble and a bounded hold time. Two instances, one per link end, are cross-connected; PRIO selects which end owns the channel after reset.

## Interface
- NREQ, 10: number of local requesters (2..16)
- SELW, $clog2(NREQ): width of sel
- TURN_CYC, 2: turnaround cycles with the channel undriven before handing over (1..15)
- MAX_HOLD, 16: OWN cycles after which a pending peer request forces release at the next packet boundary (1..255)
- PRIO, 1: 1 = owns the channel after reset; 0 = idle after reset
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester channel request; held high for the full packet
- gnt  out  NREQ  one-hot registered grant
- sel  out  SELW  binary index of the set gnt bit; 0 when gnt==0
- sel_vld  out  1  |gnt
- dir_out  out  1  1 = this end drives the channel
- out_req  out  1  ownership request to peer; connects to peer in_req
- out_gnt  out  1  one-cycle token pulse to peer; connects to peer in_gnt
- in_req  in  1  peer ownership request
- in_gnt  in  1  peer token pulse
- err  out  1  sticky protocol error

## Operation
- Direction FSM states:
  - OWN: dir_out=1; arbitration is enabled.
  - DRAIN: dir_out=0; counts the turnaround bubble.
  - IDLE: dir_out=0; the peer owns the channel.
- Reset state: OWN if PRIO=1, else IDLE.
- OWN -> DRAIN when gnt==0 (packet boundary), in_req=1, and any of the following holds:
  - req==0;
  - PRIO=0 (the low-priority end yields with local requests pending);
  - hold_cnt==MAX_HOLD.
- The release check takes precedence over issuing a new grant in the same cycle.
- DRAIN: turn_cnt counts 0..TURN_CYC-1. out_gnt=1 in the cycle where turn_cnt==TURN_CYC-1; the FSM goes to IDLE on the next cycle.
- IDLE: out_req = |req. IDLE -> OWN on in_gnt=1. out_req=0 in all other states.
- hold_cnt clears on entry to OWN, increments each OWN cycle, and saturates at MAX_HOLD (8-bit).
- Arbiter (active only in OWN):
  - Packet lock: if gnt[g]=1 and req[g]=1, keep gnt unchanged.
  - If req[g] drops, gnt[g] clears next cycle. In that same update, the arbiter picks the first set req starting at ptr, wrapping NREQ-1 -> 0, unless release is taken.
  - ptr <= g+1 mod NREQ whenever grant g is issued.
  - gnt is forced to 0 in DRAIN and IDLE.
- err is set on either of:
  - in_gnt=1 while not in IDLE;
  - a token pulse arriving while this end is in OWN.
  - err clears only on rst.
- Reset mid-operation: state goes to the PRIO-determined reset state, and the following are zeroed: gnt, ptr, hold_cnt, turn_cnt, err, out_gnt.

## Timing
- Reset values: gnt=0, sel=0, sel_vld=0, out_req=0, out_gnt=0, err=0. dir_out=PRIO.
- Grant latency: req rises at cycle t in OWN with gnt==0 -> gnt valid at t+1.
- Back-to-back packets: req[g] falls at t -> at t+1 gnt[g]=0 and the next requester is granted (zero-bubble switch).
- Handover from the release decision at cycle t:
  - DRAIN occupies t+1..t+TURN_CYC;
  - out_gnt pulses in cycle t+TURN_CYC;
  - the peer is in OWN at t+TURN_CYC+1.
  - The channel is undriven by both ends for at least TURN_CYC cycles.
- Request to ownership, non-owner: in_req is seen by the owner one cycle after IDLE req rises; minimum latency = 1 + TURN_CYC + 1 cycles.
- Simultaneous events:
  - in_req and a new local req at a packet boundary: release wins if its condition holds; otherwise grant.
  - A grant release (req[g] falling) coinciding with hold_cnt==MAX_HOLD and in_req: release is taken at the next boundary cycle, i.e. the cycle where gnt==0.

## Test plan
- Reset, PRIO=1, NREQ=10: after rst, dir_out=1 and gnt=0. req=10'h021 -> gnt=10'h001 (sel=0) one cycle later. Drop req[0] -> gnt=10'h020 (sel=5) the next cycle. Then req[5]=0 and req[0]=1 -> wrap grants bit 0.
- Packet lock: req[3] held 20 cycles while req[7]=1 -> gnt stays 10'h008 for all 20 cycles; 10'h080 one cycle after req[3] falls.
- Handshake pair, PRIO=1/0, TURN_CYC=2: LP end raises req[2], HP end has req=0 -> HP dir_out falls, 2 DRAIN cycles, out_gnt pulse, LP dir_out=1 and gnt[2]=1 within 5 cycles. Never both dir_out=1.
- Hold limit, MAX_HOLD=4: HP end streams continuous 1-cycle-gap packets while LP requests -> HP releases at the first gnt==0 cycle after hold_cnt reaches 4.
- LP yield: LP end owns with req=10'h3FF pending and in_req=1 -> releases at the first packet boundary.
- Error/reset: inject in_gnt while in OWN -> err=1 and sticky. Assert rst mid-DRAIN -> next cycle the reset state is restored with err=0 and out_gnt=0.

Source files
------------

// File: rtl/bidir_channel_ctrl.sv
// bidir_channel_ctrl: round-robin packet arbiter plus token handshake that owns one end of a bidirectional channel
//   clk, rst          clock, synchronous active-high reset
//   req / gnt, sel    per-requester packet requests, one-hot grant and its binary index
//   sel_vld           any grant active
//   dir_out           this end drives the channel
//   out_req / in_req  ownership request to / from the peer
//   out_gnt / in_gnt  one-cycle token pulse to / from the peer
//   err               sticky protocol error (token received while not idle)
module bidir_channel_ctrl #(
  parameter int NREQ = 10,
  parameter int SELW = $clog2(NREQ),
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 16,
  parameter bit PRIO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel,
  output logic            sel_vld,
  output logic            dir_out,
  output logic            out_req,
  output logic            out_gnt,
  input  logic            in_req,
  input  logic            in_gnt,
  output logic            err
);
  typedef enum logic [1:0] {OWN, DRAIN, IDLE} state_t;
  localparam state_t RST_STATE = PRIO ? OWN : IDLE;
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(NREQ - 1);
  state_t state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d, k;
  logic [7:0] hold_q, hold_d;
  logic [3:0] turn_q, turn_d;
  logic out_req_q, out_gnt_q, err_q, rel;
  // Hand the channel over only at a packet boundary; the low-priority end yields even with work pending.
  assign rel = state_q == OWN && gnt_q == '0 && in_req && (req == '0 || !PRIO || hold_q == HOLD_MAX);
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    turn_d = turn_q;
    k = '0;
    if (state_q == OWN) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 8'd1;
      if (rel) begin
        state_d = DRAIN;
        turn_d = '0;
        gnt_d = '0;
        sel_d = '0;
      end else if ((gnt_q & req) == '0) begin
        gnt_d = '0;
        sel_d = '0;
        // Scan downwards so the requester closest to ptr is the last, winning, assignment.
        for (int i = NREQ - 1; i >= 0; i--) begin
          k = SELW'((int'(ptr_q) + i) % NREQ);
          if (req[k]) begin
            gnt_d = '0;
            gnt_d[k] = 1'b1;
            sel_d = k;
            ptr_d = (k == LAST_IDX) ? '0 : k + SELW'(1);
          end
        end
      end
    end else if (state_q == DRAIN) begin
      turn_d = turn_q + 4'd1;
      if (turn_q == TURN_LAST) state_d = IDLE;
    end else if (in_gnt) begin
      state_d = OWN;
      hold_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      turn_q <= '0;
      out_req_q <= 1'b0;
      out_gnt_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      turn_q <= turn_d;
      out_req_q <= state_d == IDLE && |req;
      out_gnt_q <= state_d == DRAIN && turn_d == TURN_LAST;
      err_q <= err_q | (in_gnt && state_q != IDLE);
    end
  end
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign sel_vld = |gnt_q;
  assign dir_out = state_q == OWN;
  assign out_req = out_req_q;
  assign out_gnt = out_gnt_q;
  assign err = err_q;
endmodule

// File: tb/tb_bidir_channel_ctrl.sv
// tb_bidir_channel_ctrl: directed vectors for a standalone end plus a cross-connected high/low priority pair
module tb_bidir_channel_ctrl;
  localparam int N = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] a_req = '0;
  logic a_in_req = 1'b0, a_in_gnt = 1'b0;
  logic [N-1:0] a_gnt;
  logic [3:0] a_sel;
  logic a_vld, a_dir, a_oreq, a_ognt, a_err;
  logic [N-1:0] h_req = '0, l_req = '0, h_gnt, l_gnt;
  logic [3:0] h_sel, l_sel;
  logic h_vld, l_vld, h_dir, l_dir, h2l_req, l2h_req, h2l_gnt, l2h_gnt, h_err, l_err;
  int checks = 0, failures = 0;
  logic both_on = 1'b0;
  bidir_channel_ctrl u_a (
    .clk(clk), .rst(rst), .req(a_req), .gnt(a_gnt), .sel(a_sel), .sel_vld(a_vld), .dir_out(a_dir),
    .out_req(a_oreq), .out_gnt(a_ognt), .in_req(a_in_req), .in_gnt(a_in_gnt), .err(a_err));
  bidir_channel_ctrl #(.NREQ(N), .TURN_CYC(2), .MAX_HOLD(4), .PRIO(1'b1)) u_hp (
    .clk(clk), .rst(rst), .req(h_req), .gnt(h_gnt), .sel(h_sel), .sel_vld(h_vld), .dir_out(h_dir),
    .out_req(h2l_req), .out_gnt(h2l_gnt), .in_req(l2h_req), .in_gnt(l2h_gnt), .err(h_err));
  bidir_channel_ctrl #(.NREQ(N), .TURN_CYC(2), .MAX_HOLD(4), .PRIO(1'b0)) u_lp (
    .clk(clk), .rst(rst), .req(l_req), .gnt(l_gnt), .sel(l_sel), .sel_vld(l_vld), .dir_out(l_dir),
    .out_req(l2h_req), .out_gnt(l2h_gnt), .in_req(h2l_req), .in_gnt(h2l_gnt), .err(l_err));
  always @(negedge clk) if (h_dir && l_dir) both_on <= 1'b1;
  // ctl = {rst, in_req, in_gnt}; fl = expected {dir_out, out_req, out_gnt, err}
  typedef struct {
    logic [2:0]   ctl;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [3:0]   sel;
    logic [3:0]   fl;
  } vec_t;
  vec_t v[$];
  logic [N-1:0] s3_req [6];
  logic [N-1:0] s3_gnt [6];
  logic s3_dir [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pstep(input logic [N-1:0] h, input logic [N-1:0] l);
    @(negedge clk);
    h_req = h;
    l_req = l;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v.push_back('{3'b000, 10'h021, 10'h001, 4'd0, 4'b1000});
    v.push_back('{3'b000, 10'h020, 10'h020, 4'd5, 4'b1000});
    v.push_back('{3'b000, 10'h001, 10'h001, 4'd0, 4'b1000});
    v.push_back('{3'b000, 10'h000, 10'h000, 4'd0, 4'b1000});
    for (int i = 0; i < 20; i++) v.push_back('{3'b000, 10'h088, 10'h008, 4'd3, 4'b1000});
    v.push_back('{3'b000, 10'h080, 10'h080, 4'd7, 4'b1000});
    v.push_back('{3'b010, 10'h000, 10'h000, 4'd0, 4'b1000});
    v.push_back('{3'b010, 10'h000, 10'h000, 4'd0, 4'b0000});
    v.push_back('{3'b000, 10'h000, 10'h000, 4'd0, 4'b0010});
    v.push_back('{3'b000, 10'h000, 10'h000, 4'd0, 4'b0000});
    v.push_back('{3'b000, 10'h004, 10'h000, 4'd0, 4'b0100});
    v.push_back('{3'b001, 10'h004, 10'h000, 4'd0, 4'b1000});
    v.push_back('{3'b000, 10'h004, 10'h004, 4'd2, 4'b1000});
    v.push_back('{3'b001, 10'h000, 10'h000, 4'd0, 4'b1001});
    v.push_back('{3'b000, 10'h000, 10'h000, 4'd0, 4'b1001});
    v.push_back('{3'b010, 10'h000, 10'h000, 4'd0, 4'b0001});
    v.push_back('{3'b100, 10'h000, 10'h000, 4'd0, 4'b1000});
    v.push_back('{3'b000, 10'h012, 10'h002, 4'd1, 4'b1000});
    s3_req = '{10'h001, 10'h000, 10'h001, 10'h001, 10'h000, 10'h001};
    s3_gnt = '{10'h001, 10'h000, 10'h001, 10'h001, 10'h000, 10'h000};
    s3_dir = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst gnt", 32'(a_gnt), 32'h0);
    chk("rst sel", 32'(a_sel), 32'h0);
    chk("rst sel_vld", 32'(a_vld), 32'h0);
    chk("rst dir_out hp", 32'(a_dir), 32'h1);
    chk("rst out_req", 32'(a_oreq), 32'h0);
    chk("rst out_gnt", 32'(a_ognt), 32'h0);
    chk("rst err", 32'(a_err), 32'h0);
    chk("rst dir_out lp", 32'(l_dir), 32'h0);
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      {rst, a_in_req, a_in_gnt} = v[i].ctl;
      a_req = v[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d gnt", i), 32'(a_gnt), 32'(v[i].gnt));
      chk($sformatf("row%0d sel", i), 32'(a_sel), 32'(v[i].sel));
      chk($sformatf("row%0d sel_vld", i), 32'(a_vld), 32'(|v[i].gnt));
      chk($sformatf("row%0d dir_out", i), 32'(a_dir), 32'(v[i].fl[3]));
      chk($sformatf("row%0d out_req", i), 32'(a_oreq), 32'(v[i].fl[2]));
      chk($sformatf("row%0d out_gnt", i), 32'(a_ognt), 32'(v[i].fl[1]));
      chk($sformatf("row%0d err", i), 32'(a_err), 32'(v[i].fl[0]));
    end
    @(negedge clk);
    rst = 1'b1;
    a_req = '0;
    a_in_req = 1'b0;
    a_in_gnt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pstep(10'h000, 10'h004);
    chk("hs lp out_req", 32'(l2h_req), 32'h1);
    chk("hs hp still owns", 32'(h_dir), 32'h1);
    pstep(10'h000, 10'h004);
    chk("hs hp drains", 32'(h_dir), 32'h0);
    pstep(10'h000, 10'h004);
    chk("hs token pulse", 32'(h2l_gnt), 32'h1);
    chk("hs lp not yet", 32'(l_dir), 32'h0);
    pstep(10'h000, 10'h004);
    chk("hs lp owns", 32'(l_dir), 32'h1);
    chk("hs token one cycle", 32'(h2l_gnt), 32'h0);
    chk("hs lp out_req drop", 32'(l2h_req), 32'h0);
    pstep(10'h000, 10'h004);
    chk("hs lp gnt", 32'(l_gnt), 32'h004);
    chk("hs lp sel", 32'(l_sel), 32'h2);
    pstep(10'h001, 10'h000);
    chk("yield lp boundary gnt", 32'(l_gnt), 32'h0);
    chk("yield hp out_req", 32'(h2l_req), 32'h1);
    pstep(10'h001, 10'h3FF);
    chk("yield release beats grant", 32'(l_dir), 32'h0);
    chk("yield no new gnt", 32'(l_gnt), 32'h0);
    pstep(10'h001, 10'h3FF);
    chk("yield lp token", 32'(l2h_gnt), 32'h1);
    pstep(10'h001, 10'h3FF);
    chk("yield hp owns", 32'(h_dir), 32'h1);
    chk("yield hp out_req drop", 32'(h2l_req), 32'h0);
    pstep(10'h001, 10'h3FF);
    chk("yield hp gnt", 32'(h_gnt), 32'h001);
    for (int i = 0; i < 6; i++) begin
      pstep(s3_req[i], 10'h3FF);
      chk($sformatf("hold%0d gnt", i), 32'(h_gnt), 32'(s3_gnt[i]));
      chk($sformatf("hold%0d dir_out", i), 32'(h_dir), 32'(s3_dir[i]));
    end
    pstep(10'h000, 10'h3FF);
    chk("hold hp token", 32'(h2l_gnt), 32'h1);
    pstep(10'h000, 10'h3FF);
    chk("hold lp owns", 32'(l_dir), 32'h1);
    pstep(10'h000, 10'h3FF);
    chk("hold lp gnt resumes ptr", 32'(l_gnt), 32'h008);
    chk("pair hp err", 32'(h_err), 32'h0);
    chk("pair lp err", 32'(l_err), 32'h0);
    chk("never both own", 32'(both_on), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
